out_display: RTL
================

OUT_DISPLAY -- requirements
Module: out_display

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000: CLK cycles per displayed digit during scanning.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port CLR_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port Lo, input, 1 bit: output-register load enable (control-word bit 0).
REQ-005 SHALL have port bus_in, input, 8 bits: W-bus value to capture.
REQ-006 SHALL have port out_val, output, 8 bits: output register contents.
REQ-007 SHALL have port busy, output, 1 bit: conversion in progress.
REQ-008 SHALL have port an, output, 4 bits: digit enables, active-low; an[0] is the units digit.
REQ-009 SHALL have port seg, output, 7 bits: segments {g,f,e,d,c,b,a}, active-low.

Function
REQ-010 SHALL load out_val <= bus_in on a rising CLK edge with Lo=1 (load edge).
REQ-011 SHALL run the converter FSM: IDLE -> SHIFT on a load edge; SHIFT for exactly 8 edges; then COMMIT for 1 edge; then IDLE.
REQ-012 SHALL perform double-dabble in each SHIFT cycle: add 3 to each BCD nibble >= 5, then shift {bcd,bin} left by 1.
REQ-013 SHALL update the displayed digits only in COMMIT, on the 9th edge after the load edge.
REQ-014 SHALL assert busy in SHIFT and COMMIT only.
REQ-015 SHALL treat Lo=1 while busy as a new load: update out_val, restart SHIFT from count 0, and keep the previously committed digits until the new COMMIT.
REQ-016 SHALL blank leading zeros: hundreds blanked if 0; tens blanked if tens=0 and hundreds blanked; units never blanked; digit 3 blank.
REQ-017 SHALL scan with a refresh counter 0..REFRESH_DIV-1; on wrap, digit index advances 0->1->2->3->0.
REQ-018 SHALL drive an = ~(4'b0001 << index) and seg = code of the indexed digit.
REQ-019 SHALL use these segment codes: blank 7'b1111111, minus 7'b0111111, '0' 7'b1000000, standard codes for 1-9.
REQ-020 SHALL not disturb scanning during conversion.

Reset
REQ-021 SHALL on CLR_n=0 immediately set: out_val=0, busy=0, FSM=IDLE, committed digits = units 0 with others blank, refresh counter=0, index=0, an=4'b1110, seg=7'b1000000.
REQ-022 SHALL abort any conversion in progress on reset, with no later commit.

Configuration
REQ-023 SHALL, with OUT_DISPLAY_SIGNED_EN defined, interpret out_val as two's complement: convert |out_val| (0..128) and show minus on digit 3 when out_val[7]=1, sign latched at COMMIT.
REQ-024 SHALL, without OUT_DISPLAY_SIGNED_EN, show out_val as unsigned 0..255, with digit 3 always blank.

Structure
REQ-025 SHALL place the FSM state enum, SEG_BLANK, SEG_MINUS and the digit-to-segment function in shared package out_display_pkg.
REQ-026 SHALL implement the shift/add-3 converter as sub-module bin2bcd_dd (start, bin[7:0], busy, bcd[11:0], done).

Verification
REQ-027 SHALL cover: reset, then Lo with bus_in=8'd255 -> busy high 9 cycles, then digits 2,5,5; an=1110 shows seg for '5'.
REQ-028 SHALL cover: Lo with bus_in=8'd7 -> hundreds and tens blanked, units seg for '7'.
REQ-029 SHALL cover: Lo with 8'd100, then Lo with 8'd42 four cycles later -> "100" never committed; " 42" committed 9 edges after the second load.
REQ-030 SHALL cover: REFRESH_DIV=4 -> an steps 1110,1101,1011,0111 every 4 cycles and wraps.
REQ-031 SHALL cover: CLR_n low during SHIFT cycle 5 -> REQ-021 values without waiting for CLK, and no commit afterwards.
REQ-032 SHALL cover: bus_in=8'hF6 -> "-10" with OUT_DISPLAY_SIGNED_EN defined; " 246" without it.

Source files
------------

// File: rtl/out_display_pkg.sv
// Shared types and segment encoding for the output-register display block.
// Segment codes are active-low, ordered {g,f,e,d,c,b,a}.
package out_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } dd_state_t;

    localparam int         DD_STEPS  = 8;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/out_display_if.sv
// Bundle of the output-register signals; master drives loads, slave is the display.
interface out_display_if;
    logic       Lo;
    logic [7:0] bus_in;
    logic [7:0] out_val;
    logic       busy;
    logic [3:0] an;
    logic [6:0] seg;

    modport master (output Lo, bus_in, input out_val, busy, an, seg);
    modport slave  (input Lo, bus_in, output out_val, busy, an, seg);
endinterface

// File: rtl/out_display_bin2bcd_dd.sv
// Sequential double-dabble converter: 8 shift cycles then one commit cycle.
// A start pulse in any state restarts the conversion from the new operand.
module bin2bcd_dd
    import out_display_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        busy,
    output logic [11:0] bcd,
    output logic        done
);

    dd_state_t   r_state, w_state_nxt;
    logic [19:0] r_sr, w_sr_nxt;
    logic [2:0]  r_cnt, w_cnt_nxt;
    logic [11:0] w_adj;

    always_comb begin
        w_adj = r_sr[19:8];
        for (int i = 0; i < 3; i++) begin
            if (r_sr[8 + 4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_sr[8 + 4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_cnt_nxt   = r_cnt;
        if (start) begin
            w_state_nxt = ST_SHIFT;
            w_sr_nxt    = {12'd0, bin};
            w_cnt_nxt   = 3'd0;
        end else begin
            case (r_state)
                ST_SHIFT: begin
                    w_sr_nxt  = {w_adj[10:0], r_sr[7:0], 1'b0};
                    w_cnt_nxt = r_cnt + 3'd1;
                    if (r_cnt == 3'(DD_STEPS - 1))
                        w_state_nxt = ST_COMMIT;
                end
                ST_COMMIT: w_state_nxt = ST_IDLE;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_COMMIT);
    assign bcd  = r_sr[19:8];

endmodule

// File: rtl/out_display.sv
// Output register with BCD conversion and a 4-digit multiplexed 7-segment driver.
// Define OUT_DISPLAY_SIGNED_EN to show out_val as two's complement with a minus sign.
module out_display
    import out_display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       CLK,
    input  logic       CLR_n,
    input  logic       Lo,
    input  logic [7:0] bus_in,
    output logic [7:0] out_val,
    output logic       busy,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [7:0]      r_out_val;
    logic [7:0]      w_bin;
    logic [11:0]     w_bcd;
    logic            w_done;
    logic            w_commit;
    logic [3:0][6:0] r_dig;
    logic [CW-1:0]   r_ref;
    logic [1:0]      r_idx;
    logic [3:0]      w_h, w_t, w_u;

`ifdef OUT_DISPLAY_SIGNED_EN
    assign w_bin = bus_in[7] ? (~bus_in + 8'd1) : bus_in;
`else
    assign w_bin = bus_in;
`endif

    bin2bcd_dd u_dd (
        .clk   (CLK),
        .rst_n (CLR_n),
        .start (Lo),
        .bin   (w_bin),
        .busy  (busy),
        .bcd   (w_bcd),
        .done  (w_done)
    );

    // A load landing on the commit cycle supersedes the finishing conversion.
    assign w_commit = w_done & ~Lo;
    assign {w_h, w_t, w_u} = w_bcd;

    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n)
            r_out_val <= 8'd0;
        else if (Lo)
            r_out_val <= bus_in;
    end

    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            r_dig <= {SEG_BLANK, SEG_BLANK, SEG_BLANK, seg_of(4'd0)};
        end else if (w_commit) begin
            r_dig[0] <= seg_of(w_u);
            r_dig[1] <= (w_t == 4'd0 && w_h == 4'd0) ? SEG_BLANK : seg_of(w_t);
            r_dig[2] <= (w_h == 4'd0) ? SEG_BLANK : seg_of(w_h);
`ifdef OUT_DISPLAY_SIGNED_EN
            r_dig[3] <= r_out_val[7] ? SEG_MINUS : SEG_BLANK;
`else
            r_dig[3] <= SEG_BLANK;
`endif
        end
    end

    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            r_ref <= '0;
            r_idx <= 2'd0;
        end else if (r_ref == CW'(REFRESH_DIV - 1)) begin
            r_ref <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_ref <= r_ref + 1'b1;
        end
    end

    assign out_val = r_out_val;
    assign an      = ~(4'b0001 << r_idx);
    assign seg     = r_dig[r_idx];

endmodule
